sat_up_itl_top: RTL and testbench
=================================

// Module: sat_up_itl_top
// PURPOSE
//  Top of the SAT_UP turbo-path interleaver. Captures one serial frame whose
//  length is set by link_id, stores it in a bit memory, then on request
//  replays it one bit per request cycle in three orders at once: natural
//  order, interleaved order and deinterleaved order.
//  Sits between the uplink bit source and the turbo encoder / decoder stages.
// PARAMETERS
//  NCOL     4    interleaver columns (fixed)
//  MAXBITS  268  memory depth = NCOL*(63+4)
// PORTS
//  clk         in   1  single clock, rising edge
//  n_rst       in   1  asynchronous, active-low reset
//  link_id     in   6  frame format selector; rows R = link_id+4, N = 4*R bits
//  din         in   1  serial data bit
//  din_vld     in   1  frame start; first cycle sampled high = bit 0
//  request     in   1  read strobe, one output bit per high cycle
//  rdata       out  1  natural-order bit
//  rdata_itl   out  1  interleaved bit
//  rdata_ditl  out  1  deinterleaved bit
//  dout_vld    out  1  rdata* valid this cycle
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; write ptr, read ptr, length = 0; memory not cleared.
//  - States:
//    - IDLE -> WRITE when din_vld = 1.
//    - WRITE -> READY after N bits.
//    - READY -> WRITE when din_vld = 1 (new frame).
//  - Capture: the cycle din_vld is first seen high in IDLE/READY:
//    - mem[0] <= din; link_id latched (R, N); wptr = 1.
//    - Each following clock: mem[wptr] <= din, regardless of din_vld.
//    - After the bit N-1 write: READY, rptr = 0.
//    - din_vld during WRITE is ignored; link_id is used only at frame start.
//  - Read: in READY, request = 1 at edge t gives outputs valid at t+1
//    (1-cycle registered latency):
//    - rdata      = mem[k]
//    - rdata_itl  = mem[(k mod R)*4 + k div R]   (write row-wise, read column-wise)
//    - rdata_ditl = mem[(k mod 4)*R + k div 4]   (inverse permutation)
//    - k = rptr; rptr increments, wraps N-1 -> 0.
//  - Index math: k div R and k mod R computed from counters, no divider.
//    A row/column counter pair advances with rptr.
//  - dout_vld = 1 exactly one cycle per accepted request, otherwise 0.
//    rdata* hold their last value when dout_vld = 0.
//  - Requests in IDLE or WRITE are ignored: no pointer change, dout_vld = 0.
//  - din_vld and request in the same cycle while READY: the capture wins and
//    the request is dropped.
//  - n_rst low mid-frame or mid-read: immediate return to reset state;
//    the partial frame is discarded.
// TESTING
//  1 Reset check: n_rst low -> rdata, rdata_itl, rdata_ditl and dout_vld all 0;
//    a request before any frame -> dout_vld stays 0.
//  2 Capture: link_id = 20 (R = 24, N = 96); din_vld at bit 0;
//    din = 0,1,0,1,... for 96 cycles -> READY after 96 clocks.
//  3 Burst read after test 2: request pattern 1 on, 3 off, 2 on, 1 off, 5 on
//    (8 reads) -> dout_vld in the same 1/3/2/1/5 shape, delayed one cycle;
//    rdata = 0,1,0,1,0,1,0,1; rdata_ditl = 0,0,0,0,1,1,1,1; rdata_itl = all 0.
//  4 Full sweep: 96 requests -> rdata_itl = 24 zeros then 24 ones, alternating;
//    request 97 wraps to k = 0 (rdata = 0).
//  5 Round trip: frame A, read 96 rdata_itl bits, capture them as frame B
//    with the same link_id -> B's rdata_ditl equals A's rdata.
//  6 Overlap: din_vld pulses during WRITE are ignored; a request during WRITE
//    gives no dout_vld; reset mid-WRITE -> IDLE, outputs 0.

Source files
------------

// File: rtl/sat_up_itl_top_if.sv
// Bit-stream and read-strobe bundle between the uplink source/sink and the
// SAT_UP turbo-path interleaver.
interface sat_up_itl_top_if;
  logic [5:0] link_id;
  logic       din;
  logic       din_vld;
  logic       request;
  logic       rdata;
  logic       rdata_itl;
  logic       rdata_ditl;
  logic       dout_vld;

  modport master (
    output link_id, din, din_vld, request,
    input  rdata, rdata_itl, rdata_ditl, dout_vld
  );

  modport slave (
    input  link_id, din, din_vld, request,
    output rdata, rdata_itl, rdata_ditl, dout_vld
  );
endinterface

// File: rtl/sat_up_itl_top.sv
// SAT_UP turbo-path interleaver: captures one serial frame of 4*R bits, then
// replays it in natural, interleaved and deinterleaved order on request.
module sat_up_itl_top #(
  parameter int unsigned NCOL    = 4,
  parameter int unsigned MAXBITS = 268
) (
  input logic            clk,
  input logic            n_rst,
  sat_up_itl_top_if.slave bus
);

  localparam int unsigned AW = $clog2(MAXBITS);

  typedef enum logic [1:0] {StIdle, StWrite, StReady} state_e;

  state_e state_q, state_d;

  logic          mem_q [MAXBITS];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [6:0]    rows_q;
  // Interleave counters: ir = k mod R, iq = k div R.
  logic [6:0]    ir_q;
  logic [1:0]    iq_q;
  // Deinterleave counters: dm = k mod 4, dq = k div 4, dbase = dm*R.
  logic [1:0]    dm_q;
  logic [6:0]    dq_q;
  logic [AW-1:0] dbase_q;
  logic          rdata_q, rdata_itl_q, rdata_ditl_q, dout_vld_q;

  logic          capture, wr_en, rd_en, last_wr;
  logic [AW-1:0] n_len, itl_addr, ditl_addr;

  assign n_len     = {rows_q, 2'b00};
  assign itl_addr  = AW'(ir_q) * AW'(NCOL) + AW'(iq_q);
  assign ditl_addr = dbase_q + AW'(dq_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (capture) state_d = StWrite;
      StWrite: if (last_wr) state_d = StReady;
      StReady: if (capture) state_d = StWrite;
      default: state_d = StIdle;
    endcase
  end

  // A new frame start takes priority over a read in the same cycle.
  always_comb begin
    capture = bus.din_vld && (state_q != StWrite);
    wr_en   = (state_q == StWrite);
    last_wr = wr_en && (wptr_q == n_len - AW'(1));
    rd_en   = (state_q == StReady) && bus.request && !bus.din_vld;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[0] <= bus.din;
    end else if (wr_en) begin
      mem_q[wptr_q] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      rows_q       <= '0;
      ir_q         <= '0;
      iq_q         <= '0;
      dm_q         <= '0;
      dq_q         <= '0;
      dbase_q      <= '0;
      rdata_q      <= 1'b0;
      rdata_itl_q  <= 1'b0;
      rdata_ditl_q <= 1'b0;
      dout_vld_q   <= 1'b0;
    end else begin
      dout_vld_q <= rd_en;
      if (capture) begin
        rows_q <= {1'b0, bus.link_id} + 7'd4;
        wptr_q <= AW'(1);
      end else if (wr_en) begin
        wptr_q <= wptr_q + AW'(1);
        if (last_wr) begin
          wptr_q  <= '0;
          rptr_q  <= '0;
          ir_q    <= '0;
          iq_q    <= '0;
          dm_q    <= '0;
          dq_q    <= '0;
          dbase_q <= '0;
        end
      end else if (rd_en) begin
        rdata_q      <= mem_q[rptr_q];
        rdata_itl_q  <= mem_q[itl_addr];
        rdata_ditl_q <= mem_q[ditl_addr];
        if (rptr_q == n_len - AW'(1)) begin
          rptr_q  <= '0;
          ir_q    <= '0;
          iq_q    <= '0;
          dm_q    <= '0;
          dq_q    <= '0;
          dbase_q <= '0;
        end else begin
          rptr_q <= rptr_q + AW'(1);
          if (ir_q == rows_q - 7'd1) begin
            ir_q <= '0;
            iq_q <= iq_q + 2'd1;
          end else begin
            ir_q <= ir_q + 7'd1;
          end
          if (dm_q == 2'(NCOL - 1)) begin
            dm_q    <= '0;
            dbase_q <= '0;
            dq_q    <= dq_q + 7'd1;
          end else begin
            dm_q    <= dm_q + 2'd1;
            dbase_q <= dbase_q + AW'(rows_q);
          end
        end
      end
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.rdata_itl  = rdata_itl_q;
  assign bus.rdata_ditl = rdata_ditl_q;
  assign bus.dout_vld   = dout_vld_q;

endmodule

// File: tb/tb_sat_up_itl_top.sv
// Directed bench for sat_up_itl_top: vector table for the burst read, plus
// sequences for capture, sweep/wrap, round trip, overlap and reset.
module tb_sat_up_itl_top;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  sat_up_itl_top_if bus ();

  sat_up_itl_top dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic req;
    logic vld;
    logic rd;
    logic itl;
    logic ditl;
  } vec_t;

  int   total  = 0;
  int   passed = 0;
  int   cur_r  = 0;
  logic model [268];
  logic frame [268];
  logic a_nat [268];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a whole frame; optionally toggles din_vld, scrambles link_id and
  // raises request throughout, none of which may disturb the capture.
  task automatic capture(input int lid, input bit noisy);
    cur_r = lid + 4;
    for (int i = 0; i < 4 * cur_r; i++) begin
      bus.link_id = (i == 0 || !noisy) ? 6'(lid) : 6'(lid ^ 7);
      bus.din     = frame[i];
      bus.din_vld = (i == 0) || (noisy && (i % 5 == 2));
      bus.request = noisy;
      tick();
      model[i] = frame[i];
      check("no_vld_in_write", bus.dout_vld, 1'b0);
    end
    bus.din_vld = 1'b0;
    bus.request = 1'b0;
  endtask

  task automatic read_k(input int k);
    bus.request = 1'b1;
    tick();
    check("rd_vld", bus.dout_vld, 1'b1);
    check("rdata", bus.rdata, model[k]);
    check("rdata_itl", bus.rdata_itl, model[(k % cur_r) * 4 + k / cur_r]);
    check("rdata_ditl", bus.rdata_ditl, model[(k % 4) * cur_r + k / 4]);
  endtask

  task automatic sweep_wrap();
    for (int k = 0; k < 4 * cur_r; k++) read_k(k);
    read_k(0);
    bus.request = 1'b0;
  endtask

  vec_t vecs [13];

  initial begin
    bus.link_id = '0;
    bus.din     = 1'b0;
    bus.din_vld = 1'b0;
    bus.request = 1'b0;

    // 1: reset state, then requests in IDLE are ignored
    #12;
    check("rst_rdata", bus.rdata, 1'b0);
    check("rst_itl", bus.rdata_itl, 1'b0);
    check("rst_ditl", bus.rdata_ditl, 1'b0);
    check("rst_vld", bus.dout_vld, 1'b0);
    tick();
    n_rst = 1'b1;
    bus.request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_req_vld", bus.dout_vld, 1'b0);
    end
    bus.request = 1'b0;

    // 2: capture link_id 20 alternating pattern
    for (int i = 0; i < 96; i++) frame[i] = logic'(i % 2);
    capture(20, 1'b0);

    // 3: burst read shape 1/3/2/1/5 via vector table
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 13; i++) begin
      bus.request = vecs[i].req;
      tick();
      check("burst_vld", bus.dout_vld, vecs[i].vld);
      check("burst_rdata", bus.rdata, vecs[i].rd);
      check("burst_itl", bus.rdata_itl, vecs[i].itl);
      check("burst_ditl", bus.rdata_ditl, vecs[i].ditl);
    end

    // 4: rest of the sweep, wrap back to k = 0
    for (int k = 8; k < 96; k++) read_k(k);
    read_k(0);
    bus.request = 1'b0;
    tick();
    check("idle_after_read_vld", bus.dout_vld, 1'b0);

    // Boundary frame sizes: smallest and largest link_id
    for (int i = 0; i < 16; i++) frame[i] = logic'($urandom_range(1));
    capture(0, 1'b0);
    sweep_wrap();
    for (int i = 0; i < 268; i++) frame[i] = logic'($urandom_range(1));
    capture(63, 1'b0);
    sweep_wrap();

    // 5: round trip, interleaved output of A recaptured as B
    for (int i = 0; i < 96; i++) frame[i] = logic'($urandom_range(1));
    capture(20, 1'b0);
    for (int k = 0; k < 96; k++) begin
      a_nat[k] = frame[k];
      read_k(k);
      frame[k] = bus.rdata_itl;
    end
    capture(20, 1'b0);
    for (int k = 0; k < 96; k++) begin
      bus.request = 1'b1;
      tick();
      check("roundtrip_ditl", bus.rdata_ditl, a_nat[k]);
    end
    bus.request = 1'b0;

    // 6: noisy capture (din_vld pulses, link_id changes, requests)
    for (int i = 0; i < 96; i++) frame[i] = logic'($urandom_range(1));
    frame[95] = 1'b1;
    capture(20, 1'b1);
    sweep_wrap();
    for (int k = 1; k < 96; k++) read_k(k);
    bus.request = 1'b0;
    check("pre_rst_rdata", bus.rdata, 1'b1);
    // reset in the middle of a new frame
    bus.link_id = 6'd20;
    bus.din_vld = 1'b1;
    bus.din     = 1'b1;
    tick();
    bus.din_vld = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    #2 n_rst = 1'b0;
    #1;
    check("midrst_rdata", bus.rdata, 1'b0);
    check("midrst_itl", bus.rdata_itl, 1'b0);
    check("midrst_ditl", bus.rdata_ditl, 1'b0);
    check("midrst_vld", bus.dout_vld, 1'b0);
    tick();
    n_rst = 1'b1;
    bus.request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_req_vld", bus.dout_vld, 1'b0);
    end
    bus.request = 1'b0;
    for (int i = 0; i < 40; i++) frame[i] = logic'($urandom_range(1));
    capture(6, 1'b0);
    sweep_wrap();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
